// File: rtl/lvds_framer_pkg.sv
// lvds_framer_pkg: shared constants and helpers for the LVDS panel framer.
package lvds_framer_pkg;
  localparam logic [6:0] CLK_WORD = 7'b1100011;
  function automatic int lanes(input int bpc);
    return 3 + bpc / 8;
  endfunction
  // Colour bars W,Y,C,G,M,R,B,K: each primary is off in a fixed index bit
  function automatic logic [23:0] bar_rgb(input logic [2:0] i);
    return {{8{~i[1]}}, {8{~i[2]}}, {8{~i[0]}}};
  endfunction
endpackage

// File: rtl/lvds_lane_pack.sv
// lvds_lane_pack: registers one channel's RGB888 + DE/HS/VS as 7-bit LVDS lane words (VESA mapping).
module lvds_lane_pack
  import lvds_framer_pkg::*;
#(
  parameter int BPC = 6
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [23:0]             rgb,
  input  logic                    de,
  input  logic                    hs,
  input  logic                    vs,
  output logic [lanes(BPC)*7-1:0] lane_word
);
  localparam int LW = lanes(BPC) * 7;
  logic [5:0] r, g, b;
  logic [27:0] w;
  logic unused_bits;
  always_comb begin
    r = BPC == 8 ? rgb[21:16] : rgb[23:18];
    g = BPC == 8 ? rgb[13:8] : rgb[15:10];
    b = BPC == 8 ? rgb[5:0] : rgb[7:2];
    w = {1'b0, rgb[7:6], rgb[15:14], rgb[23:22], de, vs, hs, b, g, r};
  end
  assign unused_bits = ^{w, rgb};
  // Reset leaves HS/VS at their inactive (high) level
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) lane_word <= LW'({2'b11, 18'd0});
    else lane_word <= w[LW-1:0];
endmodule

// File: rtl/lvds_tx_framer.sv
// lvds_tx_framer: video timing, pixel handshake and lane packing; LVDS_FRAMER_TESTPAT_EN adds i_testpat colour bars.
module lvds_tx_framer
  import lvds_framer_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int BPC      = 6,
  parameter int H_ACTIVE = 960,
  parameter int H_FP     = 24,
  parameter int H_SYNC   = 16,
  parameter int H_BP     = 40,
  parameter int V_ACTIVE = 1200,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 26,
  parameter int CW       = 12
) (
  input  logic                              i_clk,
  input  logic                              i_reset,
  input  logic                              i_enable,
`ifdef LVDS_FRAMER_TESTPAT_EN
  input  logic                              i_testpat,
`endif
  input  logic [CHANNELS*24-1:0]            i_pix_data,
  input  logic                              i_pix_valid,
  output logic                              o_pix_ready,
  output logic [CW-1:0]                     o_x,
  output logic [CW-1:0]                     o_y,
  output logic                              o_frame_start,
  output logic                              o_underflow,
  output logic [CHANNELS*lanes(BPC)*7-1:0]  o_lane_word,
  output logic [6:0]                        o_clk_word
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int LW = lanes(BPC) * 7;
  logic [CW-1:0] h, v;
  logic act, de0, hs0, vs0, de1, hs1, vs1;
  logic [CHANNELS*24-1:0] src, pix1;
  always_comb begin
    act = i_enable && !i_reset;
    de0 = act && h < CW'(H_ACTIVE) && v < CW'(V_ACTIVE);
    hs0 = !(act && h >= CW'(H_ACTIVE + H_FP) && h < CW'(H_ACTIVE + H_FP + H_SYNC));
    vs0 = !(act && v >= CW'(V_ACTIVE + V_FP) && v < CW'(V_ACTIVE + V_FP + V_SYNC));
`ifdef LVDS_FRAMER_TESTPAT_EN
    o_pix_ready = de0 && !i_testpat;
    src = i_testpat ? {CHANNELS{bar_rgb(3'(32'(h) * 8 / H_ACTIVE))}} : i_pix_valid ? i_pix_data : '0;
`else
    o_pix_ready = de0;
    src = i_pix_valid ? i_pix_data : '0;
`endif
    o_x = h;
    o_y = v;
    o_frame_start = act && h == '0 && v == '0;
    o_clk_word = CLK_WORD;
  end
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset || !i_enable) begin
      h <= '0;
      v <= '0;
    end else if (h == CW'(H_TOTAL - 1)) begin
      h <= '0;
      v <= v == CW'(V_TOTAL - 1) ? '0 : v + 1'b1;
    end else h <= h + 1'b1;
  // Timing never stalls: a missing pixel becomes black and flags underflow
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      pix1 <= '0;
      de1 <= 1'b0;
      hs1 <= 1'b1;
      vs1 <= 1'b1;
      o_underflow <= 1'b0;
    end else begin
      pix1 <= de0 ? src : '0;
      de1 <= de0;
      hs1 <= hs0;
      vs1 <= vs0;
      o_underflow <= (o_underflow && !o_frame_start) || (o_pix_ready && !i_pix_valid);
    end
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    lvds_lane_pack #(.BPC(BPC)) u_pack (
      .i_clk,
      .i_reset,
      .rgb(pix1[c*24 +: 24]),
      .de(de1),
      .hs(hs1),
      .vs(vs1),
      .lane_word(o_lane_word[c*LW +: LW])
    );
  end
endmodule

// File: tb/tb_lvds_tx_framer.sv
// tb_lvds_tx_framer: directed table-driven check of two framer builds (BPC=6 and BPC=8, two channels).
module tb_lvds_tx_framer;
  typedef struct {
    int cyc;
    logic rdy;
    logic [7:0] x, y;
    logic fs, uf;
    logic [20:0] l6c0, l6c1;
    logic [27:0] l8c0, l8c1;
  } vec_t;

  localparam logic [20:0] BLK6   = {7'b0110000, 14'd0};
  localparam logic [20:0] BLK6H  = {7'b0100000, 14'd0};
  localparam logic [20:0] BLK6V  = {7'b0010000, 14'd0};
  localparam logic [20:0] BLK6VH = 21'd0;
  localparam logic [20:0] C06    = {7'b1111100, 7'b0011000, 7'b0110000};
  localparam logic [20:0] C16    = {7'b1110100, 7'b0001000, 7'b0010000};
  localparam logic [20:0] RED6   = {7'b1110000, 7'd0, 7'b0111111};
  localparam logic [20:0] K6     = {7'b1110000, 14'd0};
  localparam logic [27:0] BLK8   = {7'd0, BLK6};
  localparam logic [27:0] BLK8H  = {7'd0, BLK6H};
  localparam logic [27:0] BLK8V  = {7'd0, BLK6V};
  localparam logic [27:0] BLK8VH = 28'd0;
  localparam logic [27:0] C08    = {7'b0111111, 7'b1110000, 14'd0};
  localparam logic [27:0] C18    = {7'b0010101, 7'b1110000, 14'd0};
  localparam logic [27:0] RED8   = {7'b0000011, 7'b1110000, 7'd0, 7'b0111111};
  localparam logic [27:0] K8     = {7'd0, K6};

  logic clk = 1'b0, rst = 1'b1, en = 1'b1, valid = 1'b1;
  logic [47:0] pix = '0;
  logic rdy6, fs6, uf6, rdy8, fs8, uf8;
  logic [7:0] x6, y6, x8, y8;
  logic [41:0] lw6;
  logic [55:0] lw8;
  logic [6:0] ck6, ck8;
  int checks = 0, errors = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  lvds_tx_framer #(.CHANNELS(2), .BPC(6), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .CW(8)) dut6 (
    .i_clk(clk), .i_reset(rst), .i_enable(en), .i_pix_data(pix), .i_pix_valid(valid),
    .o_pix_ready(rdy6), .o_x(x6), .o_y(y6), .o_frame_start(fs6), .o_underflow(uf6),
    .o_lane_word(lw6), .o_clk_word(ck6));

  lvds_tx_framer #(.CHANNELS(2), .BPC(8), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .CW(8)) dut8 (
    .i_clk(clk), .i_reset(rst), .i_enable(en), .i_pix_data(pix), .i_pix_valid(valid),
    .o_pix_ready(rdy8), .o_x(x8), .o_y(y8), .o_frame_start(fs8), .o_underflow(uf8),
    .o_lane_word(lw8), .o_clk_word(ck8));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_lw(input string nm, input logic [20:0] a, b, input logic [27:0] c, d);
    chk({nm, " lane6"}, 64'(lw6), 64'({b, a}));
    chk({nm, " lane8"}, 64'(lw8), 64'({d, c}));
  endtask

  task automatic add(input int c, input logic r, input logic [7:0] x, y, input logic f, u,
                     input logic [20:0] a, b, input logic [27:0] d, e);
    vec_t t;
    t.cyc = c; t.rdy = r; t.x = x; t.y = y; t.fs = f; t.uf = u;
    t.l6c0 = a; t.l6c1 = b; t.l8c0 = d; t.l8c1 = e;
    tbl.push_back(t);
  endtask

  task automatic check_row(input vec_t t);
    string p;
    p = $sformatf("c%0d", t.cyc);
    chk({p, " ready"}, 64'(rdy6), 64'(t.rdy));
    chk({p, " ready8"}, 64'(rdy8), 64'(t.rdy));
    chk({p, " x"}, 64'(x6), 64'(t.x));
    chk({p, " y"}, 64'(y6), 64'(t.y));
    chk({p, " frame_start"}, 64'(fs6), 64'(t.fs));
    chk({p, " frame_start8"}, 64'(fs8), 64'(t.fs));
    chk({p, " underflow"}, 64'(uf6), 64'(t.uf));
    chk({p, " underflow8"}, 64'(uf8), 64'(t.uf));
    chk_lw(p, t.l6c0, t.l6c1, t.l8c0, t.l8c1);
  endtask

  initial begin
    // cycle, ready, x, y, frame_start, underflow, lanes (lanes show the slot two cycles earlier)
    add(0,   1, 0, 0, 1, 0, BLK6, BLK6, BLK8, BLK8);
    add(1,   1, 1, 0, 0, 0, BLK6, BLK6, BLK8, BLK8);
    add(2,   1, 2, 0, 0, 0, RED6, C16, RED8, C18);
    add(3,   1, 3, 0, 0, 0, C06, C16, C08, C18);
    add(7,   1, 7, 0, 0, 0, C06, C16, C08, C18);
    add(8,   0, 8, 0, 0, 0, C06, C16, C08, C18);
    add(9,   0, 9, 0, 0, 0, C06, C16, C08, C18);
    add(10,  0, 10, 0, 0, 0, BLK6, BLK6, BLK8, BLK8);
    add(11,  0, 11, 0, 0, 0, BLK6, BLK6, BLK8, BLK8);
    add(12,  0, 12, 0, 0, 0, BLK6H, BLK6H, BLK8H, BLK8H);
    add(13,  0, 13, 0, 0, 0, BLK6H, BLK6H, BLK8H, BLK8H);
    add(14,  1, 0, 1, 0, 0, BLK6, BLK6, BLK8, BLK8);
    add(17,  1, 3, 1, 0, 0, C06, C16, C08, C18);
    add(18,  1, 4, 1, 0, 1, C06, C16, C08, C18);
    add(19,  1, 5, 1, 0, 1, K6, K6, K8, K8);
    add(20,  1, 6, 1, 0, 1, C06, C16, C08, C18);
    add(56,  0, 0, 4, 0, 1, BLK6, BLK6, BLK8, BLK8);
    add(72,  0, 2, 5, 0, 1, BLK6V, BLK6V, BLK8V, BLK8V);
    add(82,  0, 12, 5, 0, 1, BLK6VH, BLK6VH, BLK8VH, BLK8VH);
    add(84,  0, 0, 6, 0, 1, BLK6V, BLK6V, BLK8V, BLK8V);
    add(86,  0, 2, 6, 0, 1, BLK6, BLK6, BLK8, BLK8);
    add(98,  1, 0, 0, 1, 1, BLK6, BLK6, BLK8, BLK8);
    add(99,  1, 1, 0, 0, 0, BLK6, BLK6, BLK8, BLK8);
    add(100, 1, 2, 0, 0, 0, C06, C16, C08, C18);
    repeat (3) @(negedge clk);
    for (int c = 0; c <= 100; c++) begin
      rst = 1'b0;
      valid = c != 17;
      pix = c == 0 ? {24'h404040, 24'hFF0000} : {24'h404040, 24'hC0C0C0};
      #1;
      foreach (tbl[i]) if (tbl[i].cyc == c) check_row(tbl[i]);
      @(negedge clk);
    end
    // enable drop at h=3: counters clear next cycle, lanes blank after two
    en = 1'b0;
    #1;
    chk("dis ready", 64'(rdy6), 64'd0);
    chk("dis x now", 64'(x6), 64'd3);
    @(negedge clk);
    #1;
    chk("dis x", 64'(x6), 64'd0);
    chk("dis y", 64'(y6), 64'd0);
    chk("dis frame_start", 64'(fs6), 64'd0);
    chk_lw("dis+1", C06, C16, C08, C18);
    @(negedge clk);
    #1;
    chk_lw("dis+2", BLK6, BLK6, BLK8, BLK8);
    @(negedge clk);
    en = 1'b1;
    #1;
    chk("reen frame_start", 64'(fs6), 64'd1);
    chk("reen ready", 64'(rdy6), 64'd1);
    @(negedge clk);
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    valid = 1'b1;
    #1;
    chk("reen underflow", 64'(uf6), 64'd1);
    @(negedge clk);
    #1;
    chk_lw("reen h4", K6, K6, K8, K8);
    @(negedge clk);
    #1;
    chk("pre-reset x", 64'(x6), 64'd5);
    chk_lw("pre-reset", C06, C16, C08, C18);
    // asynchronous reset mid-line
    rst = 1'b1;
    #1;
    chk_lw("in reset", BLK6, BLK6, BLK8, BLK8);
    chk("in reset underflow", 64'(uf6), 64'd0);
    chk("in reset x", 64'(x6), 64'd0);
    chk("in reset ready", 64'(rdy6), 64'd0);
    chk("in reset frame_start", 64'(fs6), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("restart frame_start", 64'(fs6), 64'd1);
    chk("restart xy", 64'({x6, y6}), 64'd0);
    chk("restart ready", 64'(rdy6), 64'd1);
    @(negedge clk);
    #1;
    chk_lw("restart h1", BLK6, BLK6, BLK8, BLK8);
    @(negedge clk);
    #1;
    chk_lw("restart h2", C06, C16, C08, C18);
    chk("restart xy8", 64'({x8, y8}), 64'({8'd2, 8'd0}));
    chk("clk word6", 64'(ck6), 64'(7'b1100011));
    chk("clk word8", 64'(ck8), 64'(7'b1100011));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
